// File: rtl/lif_tdm_scheduler_pkg.sv
// lif_pkg: shared constants, FSM state type and the leak/integrate arithmetic for the LIF scheduler.
package lif_pkg;
    localparam int LIF_N            = 4;
    localparam int LIF_WIDTH        = 8;
    localparam int LIF_THR_RESET    = 230;
    localparam int LIF_REFRAC_STEPS = 2;

    typedef enum logic [1:0] {IDLE, SWEEP, FIN} lif_state_t;

    // Leak keeps 7/8 of the membrane (1/2 + 1/4 + 1/8), then adds the current and clamps.
    function automatic int unsigned lif_decay_sat(input int unsigned mem, input int unsigned cur,
                                                  input int unsigned maxv);
        int unsigned sum;
        sum = cur + (mem >> 1) + (mem >> 2) + (mem >> 3);
        return (sum > maxv) ? maxv : sum;
    endfunction
endpackage

// File: rtl/lif_tdm_scheduler_if.sv
// lif_tdm_scheduler_if: host-side bus of the LIF scheduler (current/threshold writes, sweep control, spikes).
interface lif_tdm_scheduler_if
    import lif_pkg::*;
#(
    parameter int N = LIF_N,
    parameter int W = LIF_WIDTH
);
    localparam int AW = $clog2(N);
    logic          cur_we;
    logic [AW-1:0] cur_addr;
    logic [W-1:0]  cur_data;
    logic          thr_we;
    logic [W-1:0]  thr_data;
    logic          step_start;
    logic          busy;
    logic          done;
    logic          spike_valid;
    logic [AW-1:0] spike_idx;
    logic [N-1:0]  spike_vec;
    modport master (
        output cur_we, cur_addr, cur_data, thr_we, thr_data, step_start,
        input  busy, done, spike_valid, spike_idx, spike_vec
    );
    modport slave (
        input  cur_we, cur_addr, cur_data, thr_we, thr_data, step_start,
        output busy, done, spike_valid, spike_idx, spike_vec
    );
endinterface

// File: rtl/lif_tdm_scheduler_update_unit.sv
// lif_update_unit: combinational LIF neuron update -- threshold compare, leak, saturating integrate.
// hold forces a silent, zeroed neuron (refractory gating).
module lif_update_unit
    import lif_pkg::*;
#(
    parameter int W = LIF_WIDTH
) (
    input  logic [W-1:0] mem,
    input  logic [W-1:0] cur,
    input  logic [W-1:0] thr,
    input  logic         hold,
    output logic         spike,
    output logic [W-1:0] nxt
);
    localparam int unsigned MAXV = (2 ** W) - 1;
    always_comb begin
        spike = !hold && (mem >= thr);
        nxt   = (hold || spike) ? '0 : W'(lif_decay_sat(32'(mem), 32'(cur), MAXV));
    end
endmodule

// File: rtl/lif_tdm_scheduler.sv
// lif_tdm_scheduler: sweeps one LIF update unit over N_NEURONS virtual neurons per timestep and reports spikes.
// Define LIF_REFRACTORY_EN to add per-neuron refractory down-counters (REFRAC_STEPS sweeps).
module lif_tdm_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS = LIF_N,
    parameter int WIDTH     = LIF_WIDTH,
    parameter int THR_RESET = LIF_THR_RESET
`ifdef LIF_REFRACTORY_EN
    ,
    parameter int REFRAC_STEPS = LIF_REFRAC_STEPS
`endif
) (
    input logic clk,
    input logic rst_n,
    lif_tdm_scheduler_if.slave bus
);
    localparam int AW = $clog2(N_NEURONS);
    lif_state_t    st, st_nx;
    logic [AW-1:0] idx;
    logic [WIDTH-1:0] mem [N_NEURONS];
    logic [WIDTH-1:0] cur [N_NEURONS];
    logic [WIDTH-1:0] thr_sh, thr_act, nxt;
    logic pending, start, sweeping, last, spike, hold;

    assign sweeping = (st == SWEEP);
    assign last     = (idx == AW'(N_NEURONS - 1));
    // A queued request restarts straight out of FIN, skipping IDLE.
    assign start    = ((st == IDLE) && (bus.step_start || pending)) || ((st == FIN) && pending);

    always_ff @(posedge clk) begin
        if (!rst_n) st <= IDLE;
        else        st <= st_nx;
    end

    always_comb begin
        st_nx = start ? SWEEP : (sweeping && !last) ? SWEEP : sweeping ? FIN : IDLE;
    end

    always_comb begin
        bus.busy = sweeping;
        bus.done = (st == FIN);
    end

    lif_update_unit #(.W(WIDTH)) u_upd (
        .mem  (mem[idx]),
        .cur  (cur[idx]),
        .thr  (thr_act),
        .hold (hold),
        .spike(spike),
        .nxt  (nxt)
    );

`ifdef LIF_REFRACTORY_EN
    localparam int RW = $clog2(REFRAC_STEPS + 1);
    logic [RW-1:0] ref_cnt [N_NEURONS];
    assign hold = (ref_cnt[idx] != '0);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) ref_cnt[i] <= '0;
        end else if (sweeping) begin
            ref_cnt[idx] <= spike ? RW'(REFRAC_STEPS) : hold ? ref_cnt[idx] - 1'b1 : ref_cnt[idx];
        end
    end
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx             <= '0;
            thr_sh          <= WIDTH'(THR_RESET);
            thr_act         <= WIDTH'(THR_RESET);
            pending         <= 1'b0;
            bus.spike_valid <= 1'b0;
            bus.spike_idx   <= '0;
            bus.spike_vec   <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                mem[i] <= '0;
                cur[i] <= '0;
            end
        end else begin
            pending         <= (pending && !start) || (bus.step_start && (st != IDLE) && !pending);
            bus.spike_valid <= sweeping && spike;
            if (bus.thr_we) thr_sh <= bus.thr_data;
            if (start) begin
                thr_act <= thr_sh;
                idx     <= '0;
            end else if (sweeping) begin
                idx <= idx + 1'b1;
            end
            if (sweeping) begin
                mem[idx]           <= nxt;
                cur[idx]           <= '0;
                bus.spike_idx      <= idx;
                bus.spike_vec[idx] <= spike;
            end
            // Issued after the consume-clear so a same-cycle host write survives into the next sweep.
            if (bus.cur_we) cur[bus.cur_addr] <= bus.cur_data;
        end
    end
endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// tb_lif_tdm_scheduler: table-driven sweep vectors plus directed multi-cycle sequences for lif_tdm_scheduler.
// Refractory expectations switch with LIF_REFRACTORY_EN.
module tb_lif_tdm_scheduler;
    logic clk, rst_n;
    int   checks = 0;
    int   errors = 0;

    lif_tdm_scheduler_if #(.N(4), .W(8)) bus ();
    lif_tdm_scheduler #(.N_NEURONS(4), .WIDTH(8), .THR_RESET(230)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           nm;
        logic [3:0][7:0] cur;
        logic            twe;
        logic [7:0]      thr;
        logic [3:0]      ev;
    } vec_t;

    vec_t tbl [10];

    function automatic vec_t mk(input string nm, input logic [7:0] c0, input logic [7:0] c1,
                                input logic [7:0] c2, input logic [7:0] c3, input logic twe,
                                input logic [7:0] thr, input logic [3:0] ev);
        vec_t v;
        v.nm  = nm;
        v.cur = {c3, c2, c1, c0};
        v.twe = twe;
        v.thr = thr;
        v.ev  = ev;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic finish_sweep(input string nm, input int lat0, input logic [3:0] ev);
        logic [3:0] seen;
        int lat;
        seen = '0;
        lat  = lat0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.spike_valid === 1'b1) seen[bus.spike_idx] = 1'b1;
            step();
            lat++;
        end
        if (bus.spike_valid === 1'b1) seen[bus.spike_idx] = 1'b1;
        check({nm, " latency"}, 32'(lat), 32'd5);
        check({nm, " spikes"}, 32'(seen), 32'(ev));
        check({nm, " spike_vec"}, 32'(bus.spike_vec), 32'(ev));
        check({nm, " busy_at_done"}, 32'(bus.busy), 32'd0);
        step();
    endtask

    task automatic do_sweep(input string nm, input logic [3:0][7:0] c, input logic twe,
                            input logic [7:0] t, input logic [3:0] ev);
        for (int i = 0; i < 4; i++) begin
            if (c[i] != 8'd0) begin
                bus.cur_we   = 1'b1;
                bus.cur_addr = i[1:0];
                bus.cur_data = c[i];
                step();
            end
        end
        bus.cur_we = 1'b0;
        if (twe) begin
            bus.thr_we   = 1'b1;
            bus.thr_data = t;
            step();
            bus.thr_we = 1'b0;
        end
        bus.step_start = 1'b1;
        step();
        bus.step_start = 1'b0;
        check({nm, " busy"}, 32'(bus.busy), 32'd1);
        finish_sweep(nm, 1, ev);
    endtask

    task automatic sweep_cur(input string nm, input logic [7:0] c0, input logic [7:0] c1,
                             input logic [3:0] ev);
        do_sweep(nm, {8'd0, 8'd0, c1, c0}, 1'b0, 8'd0, ev);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn, d1, d2, ndone;
        logic b_after;
        tbl[0] = mk("zero",   8'd0,   8'd0, 8'd0,   8'd0,   1'b0, 8'd0,   4'b0000);
        tbl[1] = mk("int1",   8'd100, 8'd0, 8'd0,   8'd240, 1'b0, 8'd0,   4'b0000);
        tbl[2] = mk("int2",   8'd100, 8'd0, 8'd0,   8'd0,   1'b0, 8'd0,   4'b1000);
        tbl[3] = mk("int3",   8'd100, 8'd0, 8'd0,   8'd0,   1'b0, 8'd0,   4'b0000);
        tbl[4] = mk("int4",   8'd100, 8'd0, 8'd0,   8'd0,   1'b0, 8'd0,   4'b0001);
        tbl[5] = mk("after",  8'd0,   8'd0, 8'd0,   8'd0,   1'b0, 8'd0,   4'b0000);
        tbl[6] = mk("thr255", 8'd0,   8'd0, 8'd255, 8'd0,   1'b1, 8'd255, 4'b0000);
        tbl[7] = mk("eq_thr", 8'd0,   8'd0, 8'd0,   8'd0,   1'b0, 8'd0,   4'b0100);
        tbl[8] = mk("thr230", 8'd0,   8'd0, 8'd0,   8'd0,   1'b1, 8'd230, 4'b0000);
        tbl[9] = mk("quiet",  8'd0,   8'd0, 8'd0,   8'd0,   1'b0, 8'd0,   4'b0000);

        rst_n          = 1'b0;
        bus.cur_we     = 1'b0;
        bus.cur_addr   = '0;
        bus.cur_data   = '0;
        bus.thr_we     = 1'b0;
        bus.thr_data   = '0;
        bus.step_start = 1'b0;
        repeat (2) step();
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset spike_valid", 32'(bus.spike_valid), 32'd0);
        check("reset spike_vec", 32'(bus.spike_vec), 32'd0);
        rst_n = 1'b1;
        step();

        for (int r = 0; r < 10; r++) do_sweep(tbl[r].nm, tbl[r].cur, tbl[r].twe, tbl[r].thr, tbl[r].ev);

        // Three extra requests during one sweep: one queues, the rest drop.
        dn = 0; d1 = 0; d2 = 0; b_after = 1'b0;
        bus.step_start = 1'b1;
        step();
        for (int cyc = 1; cyc <= 16; cyc++) begin
            bus.step_start = (cyc == 1 || cyc == 3 || cyc == 4);
            if (d1 != 0 && cyc == d1 + 1) b_after = bus.busy;
            if (bus.done === 1'b1) begin
                dn++;
                if (dn == 1) d1 = cyc;
                else d2 = cyc;
            end
            step();
        end
        bus.step_start = 1'b0;
        check("b2b done_count", 32'(dn), 32'd2);
        check("b2b first_done", 32'(d1), 32'd5);
        check("b2b done_gap", 32'(d2 - d1), 32'd5);
        check("b2b busy_after_fin", 32'(b_after), 32'd1);

        // Host write lands in neuron 2's consume cycle.
        bus.cur_we = 1'b1; bus.cur_addr = 2'd2; bus.cur_data = 8'd100;
        step();
        bus.cur_we = 1'b0;
        bus.step_start = 1'b1;
        step();
        bus.step_start = 1'b0;
        step();
        step();
        bus.cur_we = 1'b1; bus.cur_addr = 2'd2; bus.cur_data = 8'd200;
        step();
        bus.cur_we = 1'b0;
        finish_sweep("coll_a", 4, 4'b0000);
        sweep_cur("coll_b", 8'd0, 8'd0, 4'b0000);
        sweep_cur("coll_c", 8'd0, 8'd0, 4'b0100);

        // Threshold written mid-sweep only applies from the next sweep.
        sweep_cur("thr_a", 8'd0, 8'd150, 4'b0000);
        bus.step_start = 1'b1;
        step();
        bus.step_start = 1'b0;
        bus.thr_we = 1'b1; bus.thr_data = 8'd100;
        step();
        bus.thr_we = 1'b0;
        finish_sweep("thr_b", 2, 4'b0000);
        sweep_cur("thr_c", 8'd0, 8'd0, 4'b0010);
        do_sweep("thr_d", '0, 1'b1, 8'd230, 4'b0000);

        // Reset while neuron 1 is being processed, with a request already queued.
        sweep_cur("rst_a", 8'd240, 8'd0, 4'b0000);
        bus.step_start = 1'b1;
        step();
        step();
        bus.step_start = 1'b0;
        rst_n = 1'b0;
        step();
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst done", 32'(bus.done), 32'd0);
        check("midrst spike_valid", 32'(bus.spike_valid), 32'd0);
        check("midrst spike_vec", 32'(bus.spike_vec), 32'd0);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
            step();
        end
        check("midrst no_activity", 32'(ndone), 32'd0);
        sweep_cur("rst_c", 8'd0, 8'd0, 4'b0000);

`ifdef LIF_REFRACTORY_EN
        sweep_cur("ref_a", 8'd240, 8'd0, 4'b0000);
        sweep_cur("ref_b", 8'd240, 8'd0, 4'b0001);
        sweep_cur("ref_c", 8'd240, 8'd0, 4'b0000);
        sweep_cur("ref_d", 8'd240, 8'd0, 4'b0000);
        sweep_cur("ref_e", 8'd240, 8'd0, 4'b0000);
        sweep_cur("ref_f", 8'd0,   8'd0, 4'b0001);
`else
        sweep_cur("nref_a", 8'd240, 8'd0, 4'b0000);
        sweep_cur("nref_b", 8'd240, 8'd0, 4'b0001);
        sweep_cur("nref_c", 8'd240, 8'd0, 4'b0000);
        sweep_cur("nref_d", 8'd0,   8'd0, 4'b0001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
